turf_bus_to_axis: RTL and testbench
===================================

// Module: turf_bus_to_axis
// PURPOSE
//  Bus-to-stream bridge, the inverse of the AXI4-stream request/response register master.
//  Accepts en/wr/ack register transactions and emits 2-word (64b) requests on an AXI4-stream.
//  Waits for the 2-word response and completes the bus cycle with ack_o.
//  Gives on-board logic (or a loopback bench) a way to initiate mmreq traffic.
// PARAMETERS
//  TIMEOUT_CYCLES  1024          cycles to wait for response before forced ack (>=4)
//  TIMEOUT_DATA    32'hBADC0FFE  dat_o value returned on a timed-out read
// PORTS
//  clk              in   1   single clock
//  rst              in   1   synchronous, active-high reset
//  en_i             in   1   bus request; held high until ack_o
//  wr_i             in   1   1=write, 0=read; stable while en_i
//  adr_i            in   28  register address; stable while en_i
//  dat_i            in   32  write data; stable while en_i
//  ack_o            out  1   one-cycle completion strobe
//  dat_o            out  32  read data, valid only when ack_o=1
//  m_axis_tdata     out  32  request stream data
//  m_axis_tvalid    out  1   request stream valid
//  m_axis_tready    in   1   request stream ready
//  s_axis_tdata     in   32  response stream data
//  s_axis_tvalid    in   1   response stream valid
//  s_axis_tready    out  1   response stream ready
//  timeout_o        out  1   one-cycle strobe coincident with a timed-out ack_o
//  timeout_count_o  out  16  saturating count of timeouts (saturates at 16'hFFFF)
// BEHAVIOUR
//  Reset: state=IDLE, ack_o=0, dat_o=0, m_axis_tvalid=0, s_axis_tready=0, timeout_o=0, timeout_count_o=0.
//  Request format: word0 hdr = {wr_i, 3'b000, adr_i}; word1 = dat_i (writes) or 32'h0 (reads).
//  Response format: word0 = echo of hdr; word1 = read data (reads) or written data (writes).
//  FSM:
//   IDLE:  en_i=1 -> latch hdr/dat_i, load timer=TIMEOUT_CYCLES -> REQ0.
//   REQ0:  tvalid=1, tdata=hdr; beat (tvalid&tready) -> REQ1.
//   REQ1:  tvalid=1, tdata=word1; beat -> RSP0.
//   RSP0:  tready=1; beat: if tdata==hdr -> RSP1, else -> DROP (stale pair).
//   DROP:  tready=1; beat discards word1 -> RSP0.
//   RSP1:  tready=1; beat: dat_o<=tdata, ack_o<=1 -> IDLE.
//  tvalid drops only after a beat; tdata is stable while tvalid&!tready.
//  The timer decrements every cycle in REQ0..RSP1 and never stops for backpressure.
//  At zero (no completing beat that cycle): ack_o=1, timeout_o=1, dat_o=TIMEOUT_DATA, count++ -> IDLE.
//   If REQ0/REQ1 are mid-stream at timeout: the partial request is still completed before IDLE.
//    Sub-state FLUSH: tvalid held until word1 beats, then IDLE; ack_o already given.
//   A late response arrives with a header that is stale for the next transaction; it is discarded via DROP.
//  If a completing beat coincides with timer==0: the beat wins and no timeout occurs.
//  Latency (tready=1, response immediate): en_i rise -> ack_o rise = 5 cycles min.
//  en_i is ignored outside IDLE. The master deasserts en_i on the cycle after ack_o.
//  A new en_i is sampled in IDLE only, so back-to-back transactions are 1 idle cycle apart.
//  ack_o and timeout_o are high for exactly one cycle. dat_o holds until the next ack_o.
//  Reset mid-operation: immediate return to reset values; a partial stream frame is abandoned.
// TESTING
//  Write adr=28'h0000010, dat=32'h12345678, tready=1 -> m_axis beats 32'h80000010, 32'h12345678.
//   Echo response (hdr, 32'h12345678) -> ack_o 1 cycle, timeout_o=0.
//  Read adr=28'h0000004 with response (32'h00000004, 32'hCAFEF00D) -> word1=0, dat_o=32'hCAFEF00D at ack_o.
//  Read with tready toggling 1/0 every cycle -> tdata stable under stall, exactly 2 beats, correct dat_o.
//  Stale pair (32'h00000099, x) then good pair -> stale pair consumed, ack_o only after good pair.
//  TIMEOUT_CYCLES=16, no response -> ack_o + timeout_o, dat_o=32'hBADC0FFE, timeout_count_o=1.
//   A late response is then dropped on the next read.
//  rst asserted in RSP0 -> next cycle tvalid=0, tready=0, ack_o=0. New read completes normally.

Source files
------------

// File: rtl/turf_bus_to_axis.sv
// turf_bus_to_axis: bridges en/wr/ack register cycles onto a 2-word AXI4-stream request
// and completes each cycle from the matching 2-word response, with a response timeout.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   en_i, wr_i, adr_i, dat_i      bus request (held until ack_o), direction, address, write data
//   ack_o, dat_o                  one-cycle completion strobe, read data valid with ack_o
//   m_axis_tdata/tvalid/tready    request stream (header word, then data word)
//   s_axis_tdata/tvalid/tready    response stream (echoed header, then data word)
//   timeout_o, timeout_count_o    timed-out completion strobe, saturating timeout count
module turf_bus_to_axis #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hBADC0FFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        wr_i,
    input  logic [27:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        timeout_o,
    output logic [15:0] timeout_count_o
);
    typedef enum logic [2:0] {IDLE, REQ0, REQ1, RSP0, DROP, RSP1, FLUSH0, FLUSH1} state_t;
    state_t state, state_nx;
    logic [31:0] hdr, word1, timer;
    logic active, expired, m_beat, s_beat, done, to;
    always_comb begin
        active = state inside {REQ0, REQ1, RSP0, DROP, RSP1};
        expired = active && timer == 32'd0;
        m_axis_tvalid = state inside {REQ0, REQ1, FLUSH0, FLUSH1};
        m_axis_tdata = (state == REQ0 || state == FLUSH0) ? hdr : word1;
        // A header is never accepted on the expiry cycle, so response pairs stay aligned.
        s_axis_tready = state == RSP1 || state == DROP || (state == RSP0 && !expired);
        m_beat = m_axis_tvalid && m_axis_tready;
        s_beat = s_axis_tvalid && s_axis_tready;
        done = state == RSP1 && s_beat;
        to = expired && !done;
        state_nx = state;
        case (state)
            IDLE:    state_nx = en_i ? REQ0 : IDLE;
            // A request already on the wire must finish even after the bus cycle times out.
            REQ0:    state_nx = m_beat ? (expired ? FLUSH1 : REQ1) : (expired ? FLUSH0 : REQ0);
            REQ1:    state_nx = m_beat ? (expired ? IDLE : RSP0) : (expired ? FLUSH1 : REQ1);
            RSP0:    state_nx = expired ? IDLE : !s_beat ? RSP0 : (s_axis_tdata == hdr) ? RSP1 : DROP;
            DROP:    state_nx = expired ? IDLE : s_beat ? RSP0 : DROP;
            RSP1:    state_nx = (s_beat || expired) ? IDLE : RSP1;
            FLUSH0:  state_nx = m_beat ? FLUSH1 : FLUSH0;
            FLUSH1:  state_nx = m_beat ? IDLE : FLUSH1;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hdr <= '0;
            word1 <= '0;
            timer <= '0;
            ack_o <= 1'b0;
            dat_o <= '0;
            timeout_o <= 1'b0;
            timeout_count_o <= '0;
        end else begin
            state <= state_nx;
            ack_o <= done || to;
            timeout_o <= to;
            if (done)
                dat_o <= s_axis_tdata;
            else if (to)
                dat_o <= TIMEOUT_DATA;
            if (to && timeout_count_o != 16'hFFFF)
                timeout_count_o <= timeout_count_o + 16'd1;
            if (state == IDLE && en_i) begin
                hdr <= {wr_i, 3'b000, adr_i};
                word1 <= wr_i ? dat_i : 32'h0;
                timer <= TIMEOUT_CYCLES;
            end else if (active && timer != 32'd0) begin
                timer <= timer - 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_turf_bus_to_axis.sv
// tb_turf_bus_to_axis: self-checking bench with a register-file loopback responder model.
module tb_turf_bus_to_axis;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        wr_i = 1'b0;
    logic [27:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic        ack_o;
    logic [31:0] dat_o;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        timeout_o;
    logic [15:0] timeout_count_o;

    turf_bus_to_axis #(.TIMEOUT_CYCLES(16), .TIMEOUT_DATA(32'hBADC0FFE)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .wr_i(wr_i), .adr_i(adr_i), .dat_i(dat_i),
        .ack_o(ack_o), .dat_o(dat_o),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .timeout_o(timeout_o), .timeout_count_o(timeout_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mmode = 0;
    int smode = 0;
    bit auto_rsp = 1'b1;
    bit s_gate = 1'b1;
    bit stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic [31:0] req_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] beat_log[$];
    logic [31:0] mem[logic [27:0]];
    int txn_b0 = 0;

    typedef struct {
        bit          wr;
        logic [27:0] adr;
        logic [31:0] dat;
        int          mode;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [27:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic bit next_rdy(input int mode, input bit prev);
        if (mode == 0) return 1'b1;
        if (mode == 1) return !prev;
        if (mode == 2) return prev ? bit'($urandom_range(0, 1)) : 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs after a falling edge, log the beats the next rising edge
    // will take, run the loopback responder, then wait for the next falling edge.
    task automatic cycle();
        logic [31:0] h, w;
        m_axis_tready = next_rdy(mmode, m_axis_tready);
        s_gate = next_rdy(smode, s_gate);
        s_axis_tvalid = s_gate && rsp_q.size() > 0;
        s_axis_tdata = rsp_q.size() > 0 ? rsp_q[0] : 32'h0;
        #1;
        if (stall_prev) begin
            chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("stall_tdata", m_axis_tdata, stall_data);
        end
        stall_prev = !rst && m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            req_q.push_back(m_axis_tdata);
            beat_log.push_back(m_axis_tdata);
        end
        if (!rst && s_axis_tvalid && s_axis_tready) void'(rsp_q.pop_front());
        if (auto_rsp && req_q.size() >= 2) begin
            h = req_q.pop_front();
            w = req_q.pop_front();
            if (h[31]) mem[h[27:0]] = w;
            rsp_q.push_back(h);
            rsp_q.push_back(h[31] ? w : mem_rd(h[27:0]));
        end
        @(negedge clk);
    endtask

    task automatic do_txn(input bit wr, input logic [27:0] adr, input logic [31:0] dat,
                          output logic [31:0] d, output logic to, output int lat);
        bit seen = 1'b0;
        txn_b0 = beat_log.size();
        en_i = 1'b1;
        wr_i = wr;
        adr_i = adr;
        dat_i = dat;
        lat = 0;
        d = 'x;
        to = 1'bx;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycle();
            lat++;
            if (ack_o) begin
                seen = 1'b1;
                d = dat_o;
                to = timeout_o;
            end
        end
        chk("ack_seen", 32'(seen), 32'd1);
        en_i = 1'b0;
        cycle();
        chk("ack_one_cycle", 32'(ack_o), 32'd0);
        chk("timeout_one_cycle", 32'(timeout_o), 32'd0);
        chk("dat_o_hold", dat_o, d);
    endtask

    task automatic check_beats(input logic [31:0] h, input logic [31:0] w);
        chk("beat_count", 32'(beat_log.size() - txn_b0), 32'd2);
        if (beat_log.size() >= txn_b0 + 2) begin
            chk("beat_hdr", beat_log[txn_b0], h);
            chk("beat_word1", beat_log[txn_b0 + 1], w);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_i = 1'b0;
        cycle();
        rst = 1'b0;
        req_q.delete();
        rsp_q.delete();
    endtask

    vec_t vecs[8];
    logic [31:0] d, exp_d;
    logic to;
    int lat;
    bit wr;
    logic [27:0] adr;
    logic [31:0] dat;

    initial begin
        vecs[0] = '{1'b1, 28'h0000010, 32'h12345678, 0, 5, 32'h12345678};
        vecs[1] = '{1'b0, 28'h0000010, 32'h0,        0, 5, 32'h12345678};
        vecs[2] = '{1'b1, 28'h0000004, 32'hCAFEF00D, 0, 5, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 28'h0000004, 32'h0,        0, 5, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 28'h0000004, 32'h0,        1, 0, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 28'hFFFFFFC, 32'hA5A55A5A, 1, 0, 32'hA5A55A5A};
        vecs[6] = '{1'b0, 28'hFFFFFFC, 32'h0,        0, 5, 32'hA5A55A5A};
        vecs[7] = '{1'b0, 28'h0000008, 32'h0,        0, 5, 32'h00000000};

        @(negedge clk);
        cycle();
        cycle();
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_count", 32'(timeout_count_o), 32'd0);
        rst = 1'b0;
        cycle();

        foreach (vecs[i]) begin
            mmode = vecs[i].mode;
            do_txn(vecs[i].wr, vecs[i].adr, vecs[i].dat, d, to, lat);
            chk($sformatf("vec%0d_dat", i), d, vecs[i].exp);
            chk($sformatf("vec%0d_to", i), 32'(to), 32'd0);
            if (vecs[i].lat != 0) chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check_beats({vecs[i].wr, 3'b000, vecs[i].adr}, vecs[i].wr ? vecs[i].dat : 32'h0);
        end
        mmode = 0;

        // Stale response pair queued ahead of the good one.
        rsp_q.push_back(32'h00000099);
        rsp_q.push_back(32'h0BADBEEF);
        do_txn(1'b0, 28'h0000010, 32'h0, d, to, lat);
        chk("stale_dat", d, 32'h12345678);
        chk("stale_lat", 32'(lat), 32'd7);
        chk("stale_rsp_drained", 32'(rsp_q.size()), 32'd0);

        // No response: timeout completion.
        auto_rsp = 1'b0;
        do_txn(1'b0, 28'h0000020, 32'h0, d, to, lat);
        chk("to_dat", d, 32'hBADC0FFE);
        chk("to_flag", 32'(to), 32'd1);
        chk("to_lat", 32'(lat), 32'd18);
        chk("to_count1", 32'(timeout_count_o), 32'd1);
        check_beats(32'h00000020, 32'h0);
        req_q.delete();

        // The late response for 0x20 shows up and must be dropped by the next read.
        rsp_q.push_back(32'h00000020);
        rsp_q.push_back(32'h00000055);
        auto_rsp = 1'b1;
        do_txn(1'b0, 28'h0000010, 32'h0, d, to, lat);
        chk("late_dat", d, 32'h12345678);
        chk("late_to", 32'(to), 32'd0);
        chk("late_lat", 32'(lat), 32'd7);

        // Timeout while the request itself is stalled: ack first, request still completes.
        auto_rsp = 1'b0;
        mmode = 3;
        do_txn(1'b1, 28'h0000030, 32'h77778888, d, to, lat);
        chk("flush_to", 32'(to), 32'd1);
        chk("flush_dat", d, 32'hBADC0FFE);
        chk("flush_count2", 32'(timeout_count_o), 32'd2);
        chk("flush_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("flush_hdr", m_axis_tdata, 32'h80000030);
        mmode = 0;
        cycle();
        cycle();
        chk("flush_done_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_beats(32'h80000030, 32'h77778888);
        req_q.delete();

        // Reset while waiting for the response header.
        en_i = 1'b1;
        wr_i = 1'b0;
        adr_i = 28'h0000004;
        cycle();
        cycle();
        cycle();
        chk("rsp0_tready", 32'(s_axis_tready), 32'd1);
        do_reset();
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        chk("mid_rst_ack", 32'(ack_o), 32'd0);
        chk("mid_rst_count", 32'(timeout_count_o), 32'd0);
        auto_rsp = 1'b1;
        do_txn(1'b0, 28'h0000004, 32'h0, d, to, lat);
        chk("post_rst_dat", d, 32'hCAFEF00D);
        chk("post_rst_lat", 32'(lat), 32'd5);

        // Randomised traffic with bounded backpressure on both streams.
        mmode = 2;
        smode = 2;
        for (int i = 0; i < 60; i++) begin
            wr = bit'($urandom_range(0, 1));
            adr = 28'($urandom_range(0, 7)) << 2;
            dat = $urandom;
            exp_d = wr ? dat : mem_rd(adr);
            do_txn(wr, adr, dat, d, to, lat);
            chk($sformatf("rnd%0d_dat", i), d, exp_d);
            chk($sformatf("rnd%0d_to", i), 32'(to), 32'd0);
            check_beats({wr, 3'b000, adr}, wr ? dat : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
